// File: rtl/adc_isense_pkg.sv
// Shared definitions for the current-sense ADC front end: FSM encodings,
// output saturation bounds and the offset-correction helper.
package adc_isense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] SAT_MIN = 16'h0000;
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    // raw is unsigned, off is signed, so a set bit 16 of the 17-bit sum means
    // underflow when off is negative and overflow when it is not.
    function automatic logic [15:0] sat16(input logic [15:0] raw, input logic [15:0] off);
        logic [16:0] sum;
        sum = {1'b0, raw} + {off[15], off};
        if (!sum[16])
            sat16 = sum[15:0];
        else if (off[15])
            sat16 = SAT_MIN;
        else
            sat16 = SAT_MAX;
    endfunction

endpackage

// File: rtl/adc_shift_rx.sv
// Serial receive engine: generates SCLK (idle high), counts 16 bits and
// shifts SDO in MSB first on every SCLK 0->1 transition.
module adc_shift_rx
    import adc_isense_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd4
) (
    input  logic        c,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_sdo,
    output logic        o_sclk,
    output logic        o_done,
    output logic [15:0] o_raw
);

    logic        r_active;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_bit_cnt;
    logic        r_sclk;
    logic [15:0] r_shift;
    logic        w_div_last;

    assign w_div_last = (r_div_cnt == CLK_DIV - 16'd1);
    // Asserted in the last cycle of the 16th high phase.
    assign o_done     = r_active && r_sclk && w_div_last && (r_bit_cnt == 4'd15);
    assign o_sclk     = r_sclk;
    assign o_raw      = r_shift;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_div_cnt <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_sclk    <= 1'b1;
            r_shift   <= 16'd0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_div_cnt <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_sclk    <= 1'b0;
        end else if (r_active) begin
            if (w_div_last) begin
                r_div_cnt <= 16'd0;
                if (!r_sclk) begin
                    r_sclk  <= 1'b1;
                    r_shift <= {r_shift[14:0], i_sdo};
                end else if (r_bit_cnt == 4'd15) begin
                    r_active <= 1'b0;
                end else begin
                    r_sclk    <= 1'b0;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/adc_isense.sv
// Current-sense ADC front end: conversion/readout framing, offset correction
// and saturation. Define ADC_ISENSE_FILTER_EN to average successive results.
module adc_isense
    import adc_isense_pkg::*;
#(
    parameter logic [15:0] CLK_DIV    = 16'd4,
    parameter logic [15:0] CONV_TICKS = 16'd62
) (
    input  logic        c,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] offset,
    input  logic        adc_sdo,
    output logic        adc_cs,
    output logic        adc_sclk,
    output logic [15:0] i_est,
    output logic        i_est_valid
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_tick;
    logic [15:0] r_offset;
    logic        r_cs;
    logic [15:0] r_est;
    logic        r_valid;
    logic        w_start;
    logic        w_done;
    logic        w_enter_conv;
    logic [15:0] w_raw;
    logic [15:0] w_sat;
    logic [15:0] w_est_new;

    adc_shift_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .c       (c),
        .rst     (rst),
        .i_start (w_start),
        .i_sdo   (adc_sdo),
        .o_sclk  (adc_sclk),
        .o_done  (w_done),
        .o_raw   (w_raw)
    );

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE:  if (en) w_state_next = ST_CONV;
            ST_CONV: begin
                if (r_tick == CONV_TICKS - 16'd1) begin
                    w_state_next = ST_SHIFT;
                    w_start      = 1'b1;
                end
            end
            ST_SHIFT: if (w_done) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = en ? ST_CONV : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_conv = (w_state_next == ST_CONV) && (r_state != ST_CONV);
    assign w_sat        = sat16(w_raw, r_offset);

    always_ff @(posedge c or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_tick   <= 16'd0;
            r_offset <= 16'd0;
            r_cs     <= 1'b1;
            r_est    <= 16'd0;
            r_valid  <= 1'b0;
        end else begin
            // Offset is captured only at frame start so mid-frame changes wait a frame.
            if (w_enter_conv) begin
                r_tick   <= 16'd0;
                r_offset <= offset;
            end else if (r_state == ST_CONV) begin
                r_tick <= r_tick + 16'd1;
            end
            r_cs    <= (w_state_next != ST_SHIFT);
            r_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE)
                r_est <= w_est_new;
        end
    end

`ifdef ADC_ISENSE_FILTER_EN
    logic [15:0] r_prev;
    logic        r_primed;
    logic [15:0] w_prev;
    logic [16:0] w_sum;

    assign w_prev    = r_primed ? r_prev : w_sat;
    assign w_sum     = {1'b0, w_prev} + {1'b0, w_sat};
    assign w_est_new = w_sum[16:1];

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_prev   <= 16'd0;
            r_primed <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_prev   <= w_sat;
            r_primed <= 1'b1;
        end
    end
`else
    assign w_est_new = w_sat;
`endif

    assign adc_cs      = r_cs;
    assign i_est       = r_est;
    assign i_est_valid = r_valid;

endmodule
